rib_lsu: RTL
============

RIB_LSU -- requirements
Module: rib_lsu

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 255, giving the maximum bus cycles per access before abort (1..255).
REQ-002 The module SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-003 The module SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-004 The module SHALL have port i_lsu_valid  in  1  core access request.
REQ-005 The module SHALL have port i_lsu_we  in  1  1=store, 0=load.
REQ-006 The module SHALL have port i_lsu_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 The module SHALL have port i_lsu_unsigned  in  1  zero-extend loads when 1.
REQ-008 The module SHALL have port i_lsu_addr  in  32  byte address.
REQ-009 The module SHALL have port i_lsu_wdata  in  32  store data, right-aligned.
REQ-010 The module SHALL have ports o_lsu_ready (out, 1, can accept), o_lsu_done (out, 1, one-cycle completion pulse), o_lsu_rdata (out, 32, extended load data), o_lsu_err (out, 1, error qualifier valid with done).
REQ-011 The module SHALL have RIB master ports o_ribm_addr (out, 32), o_ribm_wrcs (out, 1), o_ribm_mask (out, 4), o_ribm_wdata (out, 32), i_ribm_rdata (in, 32), o_ribm_req (out, 1), i_ribm_gnt (in, 1), i_ribm_rsp (in, 1), o_ribm_rdy (out, 1).

Function
REQ-012 The FSM SHALL have states IDLE, REQ, WAIT, DONE; o_lsu_ready=1 only in IDLE.
REQ-013 In IDLE with i_lsu_valid=1, the access SHALL be registered (addr, we, size, unsigned, lane-steered wdata, mask) and the FSM SHALL move to REQ; a clean access returns to IDLE in 4 cycles.
REQ-014 In REQ: o_ribm_req=1; on i_ribm_gnt=1, move to WAIT in the same edge; req SHALL drop after grant.
REQ-015 In WAIT: o_ribm_rdy=1; on i_ribm_rsp=1, capture i_ribm_rdata (loads) and move to DONE.
REQ-016 In DONE: o_lsu_done=1 for exactly one cycle, o_lsu_rdata valid; next state IDLE.
REQ-017 o_ribm_addr SHALL be {addr[31:2],2'b00}; o_ribm_wrcs=we.
REQ-018 Store mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; wdata replicated per lane (byte x4, half x2).
REQ-019 Load extraction: byte lane addr[1:0], half lane addr[1]; sign- or zero-extended per i_lsu_unsigned; word unmodified.
REQ-020 A cycle counter SHALL run in REQ and WAIT; at TIMEOUT_CYC without rsp, go to DONE with o_lsu_err=1, o_lsu_rdata=0, req low.
REQ-021 o_lsu_rdata SHALL hold its last value outside DONE; o_lsu_err=0 when o_lsu_done=0.
REQ-022 i_ribm_rsp outside WAIT and i_ribm_gnt outside REQ SHALL be ignored.

Reset
REQ-023 On i_rst=1: state IDLE, counter 0, o_ribm_req=0, o_ribm_rdy=0, o_lsu_done=0, o_lsu_err=0, o_lsu_rdata=0, o_ribm_mask=0; an in-flight access is abandoned without a done pulse.

Configuration
REQ-024 With LSU_MISALIGN_TRAP_EN defined, half with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE->DONE with o_lsu_err=1, issuing no bus request.
REQ-025 Without LSU_MISALIGN_TRAP_EN, offending low address bits SHALL be ignored (half aligned to addr[1], word to addr[31:2]) and the access proceeds normally.

Structure
REQ-026 Package lsu_pkg SHALL hold size encodings, the FSM state encoding and the mask base constants.
REQ-027 Lane steering and extension SHALL be a combinational sub-module lsu_align; the FSM and counter stay in rib_lsu.

Verification
REQ-028 Word store 0x100, data 0xDEADBEEF, gnt=req, rsp 1 cycle later -> mask 1111, addr 0x100, done on cycle 4, err=0.
REQ-029 Byte load 0x103, signed, bus word 0x80FF0011 -> rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-030 Half store 0x102, data 0x0000ABCD -> mask 1100, wdata 0xABCDABCD.
REQ-031 gnt held low, TIMEOUT_CYC=8 -> done with err=1, rdata 0, req deasserted.
REQ-032 Word load 0x101 with LSU_MISALIGN_TRAP_EN -> no o_ribm_req, done with err=1 on the 2nd cycle; i_rst asserted in WAIT -> IDLE next cycle, no done pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the RIB load/store unit.
//   lsu_size_e  : core access size encoding (2'b11 behaves as a word)
//   lsu_state_e : bus sequencing FSM states
//   MASK_*      : base byte-enable patterns, shifted into place by lane
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_WORD3 = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   Store side: st_size, st_addr_lo, st_wdata -> st_mask (byte enables),
//               st_lane_wdata (right-aligned data replicated to every lane).
//   Load side : ld_size, ld_addr_lo, ld_unsigned, ld_bus_data -> ld_data
//               (selected byte/half, sign- or zero-extended; words untouched).
// Misaligned low address bits are simply ignored: a half uses addr[1] only,
// a word ignores addr[1:0].
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  output logic [31:0] st_lane_wdata,
  input  lsu_size_e   ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_bus_data,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    st_mask       = MASK_WORD;
    st_lane_wdata = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_mask       = MASK_BYTE << st_addr_lo;
        st_lane_wdata = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_mask       = MASK_HALF << {st_addr_lo[1], 1'b0};
        st_lane_wdata = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_bus_data[7:0];
    case (ld_addr_lo)
      2'd1:    ld_byte = ld_bus_data[15:8];
      2'd2:    ld_byte = ld_bus_data[23:16];
      2'd3:    ld_byte = ld_bus_data[31:24];
      default: ;
    endcase
    ld_half = ld_addr_lo[1] ? ld_bus_data[31:16] : ld_bus_data[15:0];

    ld_data = ld_bus_data;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/rib_lsu.sv
// RIB load/store unit: takes one core access at a time and runs it as a
// single request/grant, ready/response transaction on the RIB master port.
//   Core side : i_lsu_valid/we/size/unsigned/addr/wdata in;
//               o_lsu_ready (IDLE only), o_lsu_done (1-cycle pulse),
//               o_lsu_rdata (extended load data, held between accesses),
//               o_lsu_err (abort qualifier, only with done).
//   Bus side  : o_ribm_addr (word aligned), o_ribm_wrcs, o_ribm_mask,
//               o_ribm_wdata, o_ribm_req/i_ribm_gnt, o_ribm_rdy/i_ribm_rsp,
//               i_ribm_rdata.
// TIMEOUT_CYC bounds the cycles spent in REQ+WAIT before the access aborts.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses finish
// immediately with an error and never reach the bus.
module rib_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_we,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_unsigned,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_ready,
  output logic        o_lsu_done,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_err,
  output logic [31:0] o_ribm_addr,
  output logic        o_ribm_wrcs,
  output logic [3:0]  o_ribm_mask,
  output logic [31:0] o_ribm_wdata,
  input  logic [31:0] i_ribm_rdata,
  output logic        o_ribm_req,
  input  logic        i_ribm_gnt,
  input  logic        i_ribm_rsp,
  output logic        o_ribm_rdy
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e  state;
  lsu_size_e   r_size;
  logic [1:0]  r_addr_lo;
  logic        r_unsigned;
  logic [7:0]  cnt;

  logic [3:0]  st_mask;
  logic [31:0] st_lane_wdata;
  logic [31:0] ld_data;

  lsu_align u_align (
    .st_size       (lsu_size_e'(i_lsu_size)),
    .st_addr_lo    (i_lsu_addr[1:0]),
    .st_wdata      (i_lsu_wdata),
    .st_mask       (st_mask),
    .st_lane_wdata (st_lane_wdata),
    .ld_size       (r_size),
    .ld_addr_lo    (r_addr_lo),
    .ld_unsigned   (r_unsigned),
    .ld_bus_data   (i_ribm_rdata),
    .ld_data       (ld_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (lsu_size_e'(i_lsu_size))
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = i_lsu_addr[0];
      default: misaligned = |i_lsu_addr[1:0];
    endcase
  end
`endif

  assign o_lsu_ready = (state == ST_IDLE);

  // NOTE: state and every registered output use non-blocking assignments so
  // all of them see the same pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Datapath registers are cleared too, so the bus never sees stale
      // enables or data after reset.
      state        <= ST_IDLE;
      cnt          <= '0;
      r_size       <= SZ_BYTE;
      r_addr_lo    <= '0;
      r_unsigned   <= 1'b0;
      o_ribm_addr  <= '0;
      o_ribm_wrcs  <= 1'b0;
      o_ribm_mask  <= '0;
      o_ribm_wdata <= '0;
      o_ribm_req   <= 1'b0;
      o_ribm_rdy   <= 1'b0;
      o_lsu_done   <= 1'b0;
      o_lsu_err    <= 1'b0;
      o_lsu_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_lsu_valid) begin
            r_size       <= lsu_size_e'(i_lsu_size);
            r_addr_lo    <= i_lsu_addr[1:0];
            r_unsigned   <= i_lsu_unsigned;
            o_ribm_addr  <= {i_lsu_addr[31:2], 2'b00};
            o_ribm_wrcs  <= i_lsu_we;
            o_ribm_mask  <= st_mask;
            o_ribm_wdata <= st_lane_wdata;
            cnt          <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned) begin
              state       <= ST_DONE;
              o_lsu_done  <= 1'b1;
              o_lsu_err   <= 1'b1;
              o_lsu_rdata <= '0;
            end else
`endif
            begin
              state      <= ST_REQ;
              o_ribm_req <= 1'b1;
            end
          end
        end

        // The timeout is checked first: an access that reaches its cycle
        // budget aborts even if the grant arrives in that same cycle.
        ST_REQ: begin
          if (cnt == CNT_LAST) begin
            state       <= ST_DONE;
            o_ribm_req  <= 1'b0;
            o_lsu_done  <= 1'b1;
            o_lsu_err   <= 1'b1;
            o_lsu_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
            if (i_ribm_gnt) begin
              state      <= ST_WAIT;
              o_ribm_req <= 1'b0;
              o_ribm_rdy <= 1'b1;
            end
          end
        end

        // A response in the final budget cycle still completes cleanly.
        ST_WAIT: begin
          if (i_ribm_rsp) begin
            state      <= ST_DONE;
            o_ribm_rdy <= 1'b0;
            o_lsu_done <= 1'b1;
            o_lsu_err  <= 1'b0;
            if (!o_ribm_wrcs) o_lsu_rdata <= ld_data;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_DONE;
            o_ribm_rdy  <= 1'b0;
            o_lsu_done  <= 1'b1;
            o_lsu_err   <= 1'b1;
            o_lsu_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          o_lsu_done <= 1'b0;
          o_lsu_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
